oflow_apb_master: RTL



---
 rtl/oflow_apb_pkg.sv | 17 +
 rtl/oflow_apb_master_if.sv | 43 ++++
 rtl/oflow_apb_timeout_cnt.sv | 42 ++++
 rtl/oflow_apb_master.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/oflow_apb_pkg.sv
// Shared types and constants for the oflow APB initiator.
// The optional transfer timeout is enabled with OFLOW_APB_MASTER_TIMEOUT_EN.
package oflow_apb_pkg;

  // Register address width of the oflow register file.
  localparam int ADDR_LEN = 8;

  // Default number of stalled ACCESS cycles tolerated before an abort.
  localparam int APB_DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_t;

endpackage : oflow_apb_pkg

// File: rtl/oflow_apb_master_if.sv
// Command/response stream plus APB3 bus of the oflow configuration path.
// "master" is the initiator's view, "slave" is the view of the host driver
// together with the register file.
interface oflow_apb_master_if;
  import oflow_apb_pkg::*;

  // Command stream
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_LEN-1:0] req_addr;
  logic [31:0]         req_wdata;

  // Completion stream
  logic                rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_error;
  logic                busy;

  // APB3 bus
  logic                apb_psel;
  logic                apb_penable;
  logic                apb_pwrite;
  logic [ADDR_LEN-1:0] apb_addr;
  logic [31:0]         apb_pwdata;
  logic                apb_pready;
  logic [31:0]         apb_prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  apb_pready, apb_prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
    output apb_psel, apb_penable, apb_pwrite, apb_addr, apb_pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output apb_pready, apb_prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
    input  apb_psel, apb_penable, apb_pwrite, apb_addr, apb_pwdata
  );

endinterface : oflow_apb_master_if

// File: rtl/oflow_apb_timeout_cnt.sv
// Stall counter for ACCESS cycles: cleared before each ACCESS phase, counts
// cycles without pready and flags when the configured limit is reached.
// Used only when OFLOW_APB_MASTER_TIMEOUT_EN is defined.
module oflow_apb_timeout_cnt #(
  parameter int LIMIT = 16,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic srst,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise saturating increment on a stall.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == LIMIT_V);

endmodule : oflow_apb_timeout_cnt

// File: rtl/oflow_apb_master.sv
// APB3 initiator for the oflow register file. Accepts one command at a time,
// runs a SETUP/ACCESS transfer and returns a single-cycle completion pulse
// with read data and error status.
// Optional stalled-transfer timeout: define OFLOW_APB_MASTER_TIMEOUT_EN.
module oflow_apb_master
  import oflow_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT,
  parameter int TO_CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset_N,
  oflow_apb_master_if.master bus
);

  apb_state_t          state_q, state_d;

  // Holding registers for the accepted command; they drive the APB bus.
  logic                hold_write_q, hold_write_d;
  logic [ADDR_LEN-1:0] hold_addr_q,  hold_addr_d;
  logic [31:0]         hold_wdata_q, hold_wdata_d;

  // Completion registers.
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_error_q, rsp_error_d;

  logic                req_ready;
  logic                accept;
  logic                xfer_done;
  logic                xfer_abort;
  logic                to_hit;

  // Ready is suppressed while reset is held so nothing is accepted then.
  assign req_ready = (state_q == APB_IDLE) && !reset_N;
  assign accept    = bus.req_valid && req_ready;

`ifdef OFLOW_APB_MASTER_TIMEOUT_EN
  // Counter is cleared in SETUP so every ACCESS phase starts from zero.
  oflow_apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (TO_CNT_W)
  ) u_timeout_cnt (
    .clk   (clk),
    .srst  (reset_N),
    .clr_i (state_q == APB_SETUP),
    .inc_i ((state_q == APB_ACCESS) && !bus.apb_pready),
    .hit_o (to_hit)
  );
`else
  assign to_hit = 1'b0;
`endif

  // Next-state logic; pready on the limit cycle takes priority over abort.
  always_comb begin
    state_d    = state_q;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    case (state_q)
      APB_IDLE: begin
        if (accept) begin
          state_d = APB_SETUP;
        end
      end
      APB_SETUP: begin
        state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (bus.apb_pready) begin
          xfer_done = 1'b1;
          state_d   = APB_IDLE;
        end else if (to_hit) begin
          xfer_abort = 1'b1;
          state_d    = APB_IDLE;
        end
      end
      default: begin
        state_d = APB_IDLE;
      end
    endcase
  end

  // Holding-register and completion next values.
  always_comb begin
    hold_write_d = hold_write_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_error_d  = rsp_error_q;
    if (accept) begin
      hold_write_d = bus.req_write;
      hold_addr_d  = bus.req_addr;
      hold_wdata_d = bus.req_wdata;
    end
    if (xfer_done) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = hold_write_q ? 32'h0 : bus.apb_prdata;
      rsp_error_d = 1'b0;
    end else if (xfer_abort) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = 32'h0;
      rsp_error_d = 1'b1;
    end
  end

  // State, holding and completion registers; reset drops any transfer.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      state_q      <= APB_IDLE;
      hold_write_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= 32'h0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_write_q <= hold_write_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  // Bus outputs. Address, data and direction come straight from the holding
  // registers, so they keep their last value in IDLE.
  assign bus.req_ready   = req_ready;
  assign bus.busy        = (state_q != APB_IDLE);
  assign bus.apb_psel    = (state_q != APB_IDLE);
  assign bus.apb_penable = (state_q == APB_ACCESS);
  assign bus.apb_pwrite  = hold_write_q;
  assign bus.apb_addr    = hold_addr_q;
  assign bus.apb_pwdata  = hold_wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_error   = rsp_error_q;

endmodule : oflow_apb_master
